run_monitor: RTL

- Synthesizable run-control and watchdog block for the albaCore system.
- Observes the processor controller state and bus address, then gates processor execution through cpu_run.
- Flags a normal quit, a breakpoint hit, or a watchdog timeout.
- Counts cycles and fetched instructions.
- Parametrised successor to the bench-only "run until quit state" loop, usable in silicon and in benches alike.

---
 rtl/run_monitor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/run_monitor.sv
// run_monitor: run-control and watchdog for the albaCore processor.
// Watches the controller state and address bus, gates execution via
// cpu_run, and reports quit / breakpoint / watchdog outcomes together
// with saturating cycle and fetched-instruction counts.
module run_monitor #(
   parameter int                 STATE_W     = 5,
   parameter logic [STATE_W-1:0] QUIT_STATE  = 5'd18,
   parameter logic [STATE_W-1:0] FETCH_STATE = 5'd0,
   parameter int                 ADDR_W      = 16,
   parameter int                 CNT_W       = 32,
   parameter int                 TIMEOUT     = 100000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               resume,
   input  logic               clear,
   input  logic [STATE_W-1:0] cpu_state,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic               brk_en,
   input  logic [ADDR_W-1:0]  brk_addr,
   output logic               cpu_run,
   output logic               running,
   output logic               done,
   output logic               timed_out,
   output logic               break_hit,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [CNT_W-1:0]   instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_BREAK,
      S_DONE,
      S_TIMEOUT
   } state_t;

   // Last cycle_count value before the watchdog trips; unused when TIMEOUT is 0.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam bit               TO_EN   = (TIMEOUT != 0);

   state_t state;
   state_t state_nxt;
   logic   skip;
   logic   is_fetch;
   logic   is_quit;
   logic   brk_match;
   logic   to_match;
   logic   cyc_sat;
   logic   ins_sat;

   // Event decodes from the observed processor state.
   always_comb begin
      is_fetch  = (cpu_state == FETCH_STATE);
      is_quit   = (cpu_state == QUIT_STATE);
      brk_match = brk_en && !skip && is_fetch && (cpu_addr == brk_addr);
      to_match  = TO_EN && (cycle_count == TO_LAST);
      cyc_sat   = (cycle_count == '1);
      ins_sat   = (instr_count == '1);
   end

   // Next-state selection; within RUN the order is clear, quit, break, watchdog.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (!clear && start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (clear)          state_nxt = S_IDLE;
            else if (is_quit)   state_nxt = S_DONE;
            else if (brk_match) state_nxt = S_BREAK;
            else if (to_match)  state_nxt = S_TIMEOUT;
         end
         S_BREAK: begin
            if (clear)       state_nxt = S_IDLE;
            else if (resume) state_nxt = S_RUN;
         end
         S_DONE, S_TIMEOUT: begin
            if (clear) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, registered Moore outputs, counters and the breakpoint skip flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cpu_run     <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         timed_out   <= 1'b0;
         break_hit   <= 1'b0;
         cycle_count <= '0;
         instr_count <= '0;
         skip        <= 1'b0;
      end else begin
         state     <= state_nxt;
         // Outputs decode the next state so they line up with the state register.
         cpu_run   <= (state_nxt == S_RUN);
         running   <= (state_nxt == S_RUN);
         done      <= (state_nxt == S_DONE);
         timed_out <= (state_nxt == S_TIMEOUT);
         break_hit <= (state_nxt == S_BREAK);

         if (state == S_IDLE && state_nxt == S_RUN) begin
            cycle_count <= '0;
            instr_count <= '0;
         end else if (state == S_RUN) begin
            if (!cyc_sat)             cycle_count <= cycle_count + 1'b1;
            if (is_fetch && !ins_sat) instr_count <= instr_count + 1'b1;
         end

         // Resuming sets skip so the still-frozen fetch cannot re-trigger the break.
         if (state == S_BREAK && state_nxt == S_RUN) skip <= 1'b1;
         else if (state == S_RUN && !is_fetch)     skip <= 1'b0;
      end
   end

endmodule
